// File: rtl/mjr_pipe_buffer.sv
// Two-entry valid/ready buffer with three stored copies per entry, voted on read.
// Single-copy upsets are scrubbed in place and counted in a saturating counter.
module mjr_pipe_buffer #(
  parameter int P_DATA_SIZE = 32,
  parameter int P_CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_DATA_SIZE-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_DATA_SIZE-1:0] out_data_1,
  output logic [P_DATA_SIZE-1:0] out_data_2,
  output logic [P_DATA_SIZE-1:0] out_data_3,
  output logic                   out_we,
  input  logic                   inj_en,
  input  logic [1:0]             inj_sel,
  input  logic [P_DATA_SIZE-1:0] inj_mask,
  input  logic                   err_clr,
  output logic                   correctable_error,
  output logic [P_CNT_WIDTH-1:0] err_count
);

  logic [P_DATA_SIZE-1:0] c0_q [2];
  logic [P_DATA_SIZE-1:0] c1_q [2];
  logic [P_DATA_SIZE-1:0] c2_q [2];
  logic [P_DATA_SIZE-1:0] c0_d [2];
  logic [P_DATA_SIZE-1:0] c1_d [2];
  logic [P_DATA_SIZE-1:0] c2_d [2];
  logic [P_DATA_SIZE-1:0] voted [2];

  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [P_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                   corr_q, corr_d;

  logic [1:0]             occ;
  logic [1:0]             mism;
  logic [1:0]             n_mism;
  logic [P_CNT_WIDTH:0]   err_sum;
  logic                   push, pop, inj_act;
  logic [P_DATA_SIZE-1:0] head_vote;

  assign in_ready  = ~rst & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign inj_act   = inj_en & (inj_sel != 2'd3) & out_valid & ~pop;

  always_comb begin
    for (int e = 0; e < 2; e++) begin
      voted[e] = (c0_q[e] & c1_q[e]) | (c1_q[e] & c2_q[e]) | (c0_q[e] & c2_q[e]);
      occ[e]   = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(e)));
      mism[e]  = occ[e] && ((c0_q[e] != c1_q[e]) || (c1_q[e] != c2_q[e]));
    end
  end

  assign head_vote  = out_valid ? voted[rd_ptr_q] : '0;
  assign out_data_1 = head_vote;
  assign out_data_2 = head_vote;
  assign out_data_3 = head_vote;
  assign out_we     = pop;

  // Priority per entry: fresh write, then injection, then scrub. A pushed entry
  // is never occupied, and an injected head must keep its upset for one cycle.
  always_comb begin
    for (int e = 0; e < 2; e++) begin
      c0_d[e] = c0_q[e];
      c1_d[e] = c1_q[e];
      c2_d[e] = c2_q[e];
      if (push && (wr_ptr_q == 1'(e))) begin
        c0_d[e] = in_data;
        c1_d[e] = in_data;
        c2_d[e] = in_data;
      end else if (inj_act && (rd_ptr_q == 1'(e))) begin
        case (inj_sel)
          2'd0:    c0_d[e] = c0_q[e] ^ inj_mask;
          2'd1:    c1_d[e] = c1_q[e] ^ inj_mask;
          2'd2:    c2_d[e] = c2_q[e] ^ inj_mask;
          default: ;
        endcase
      end else if (mism[e] && !(pop && (rd_ptr_q == 1'(e)))) begin
        c0_d[e] = voted[e];
        c1_d[e] = voted[e];
        c2_d[e] = voted[e];
      end
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    n_mism  = {1'b0, mism[0]} + {1'b0, mism[1]};
    err_sum = {1'b0, err_cnt_q} + (P_CNT_WIDTH + 1)'(n_mism);
    corr_d  = |mism;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_sum[P_CNT_WIDTH]) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = err_sum[P_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 2; e++) begin
        c0_q[e] <= '0;
        c1_q[e] <= '0;
        c2_q[e] <= '0;
      end
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= '0;
      corr_q    <= 1'b0;
    end else begin
      for (int e = 0; e < 2; e++) begin
        c0_q[e] <= c0_d[e];
        c1_q[e] <= c1_d[e];
        c2_q[e] <= c2_d[e];
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      corr_q    <= corr_d;
    end
  end

  assign correctable_error = corr_q;
  assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_mjr_pipe_buffer.sv
// Directed bench for mjr_pipe_buffer: words pushed go into an expected queue,
// a negedge monitor pops and compares whenever the DUT hands a word downstream.
module tb_mjr_pipe_buffer;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data_1, out_data_2, out_data_3;
  logic          out_we;
  logic          inj_en;
  logic [1:0]    inj_sel;
  logic [DW-1:0] inj_mask;
  logic          err_clr;
  logic          correctable_error;
  logic [CW-1:0] err_count;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  mjr_pipe_buffer #(.P_DATA_SIZE(DW), .P_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
    .out_we(out_we),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .err_clr(err_clr), .correctable_error(correctable_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record the push the DUT will take at the coming edge, then advance one cycle.
  task automatic cyc();
    if (in_valid && in_ready) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", out_data_1);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("pop_data_1", out_data_1, e);
        chk("pop_data_2", out_data_2, e);
        chk("pop_data_3", out_data_3, e);
        chk("pop_we", out_we, 1'b1);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 1'b1;
    inj_en = 0; inj_sel = 2'd0; inj_mask = '0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data_1, 32'h0);
    chk("rst_err_count", err_count, 2'd0);
    chk("rst_corr", correctable_error, 1'b0);
    chk("rst_out_we", out_we, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // basic flow
    out_ready = 0;
    in_valid = 1; in_data = 32'hA5A5A5A5; cyc();
    in_data = 32'h5A5A5A5A; cyc();
    in_valid = 0;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_head", out_data_1, 32'hA5A5A5A5);
    out_ready = 1; cyc(); cyc(); out_ready = 0;
    chk("drained_valid", out_valid, 1'b0);
    chk("drained_data", out_data_1, 32'h0);

    // full plus simultaneous push/pop
    in_valid = 1; in_data = 32'h1111_0001; cyc();
    in_data = 32'h2222_0002; cyc();
    in_data = 32'h3333_0003; out_ready = 1; cyc();
    chk("after_pop_only_head", out_data_1, 32'h2222_0002);
    cyc();
    chk("pushpop_valid", out_valid, 1'b1);
    chk("pushpop_ready", in_ready, 1'b1);
    chk("pushpop_head", out_data_1, 32'h3333_0003);
    in_valid = 0; cyc(); out_ready = 0;
    chk("pushpop_drained", out_valid, 1'b0);

    // injection and scrub
    in_valid = 1; in_data = 32'h0000FFFF; cyc(); in_valid = 0;
    inj_en = 1; inj_sel = 2'd1; inj_mask = 32'h1; cyc(); inj_en = 0;
    chk("inj_vote", out_data_1, 32'h0000FFFF);
    chk("inj_corr_early", correctable_error, 1'b0);
    cyc();
    chk("inj_corr_pulse", correctable_error, 1'b1);
    chk("inj_err_count", err_count, 2'd1);
    cyc();
    chk("inj_corr_once", correctable_error, 1'b0);
    // second copy upset: only voted correctly if copy 1 was scrubbed
    inj_en = 1; inj_sel = 2'd2; inj_mask = 32'h1; cyc(); inj_en = 0;
    chk("scrubbed_vote", out_data_1, 32'h0000FFFF);
    chk("scrubbed_vote_3", out_data_3, 32'h0000FFFF);
    cyc(); cyc();
    chk("inj2_err_count", err_count, 2'd2);

    // ignored injections
    inj_en = 1; inj_sel = 2'd3; inj_mask = 32'hFFFFFFFF; cyc(); inj_en = 0; cyc();
    chk("sel3_corr", correctable_error, 1'b0);
    chk("sel3_err", err_count, 2'd2);
    inj_en = 1; inj_sel = 2'd0; inj_mask = 32'h1; out_ready = 1; cyc();
    inj_en = 0; out_ready = 0; cyc();
    chk("popinj_corr", correctable_error, 1'b0);
    chk("popinj_err", err_count, 2'd2);
    inj_en = 1; cyc(); inj_en = 0; cyc();
    chk("emptyinj_corr", correctable_error, 1'b0);
    in_valid = 1; in_data = 32'h12345678; cyc(); in_valid = 0; cyc(); cyc();
    chk("emptyinj_err", err_count, 2'd2);
    chk("emptyinj_corr2", correctable_error, 1'b0);
    chk("emptyinj_data", out_data_1, 32'h12345678);

    // saturation and clear
    err_clr = 1; cyc(); err_clr = 0;
    chk("clr_err", err_count, 2'd0);
    for (int i = 0; i < 5; i++) begin
      inj_en = 1; inj_sel = 2'(i % 3); inj_mask = 32'h0000_0100 << i; cyc();
      inj_en = 0; cyc(); cyc();
      chk("sat_err", err_count, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
    end
    chk("sat_data", out_data_2, 32'h12345678);
    inj_en = 1; inj_sel = 2'd0; inj_mask = 32'h8000_0000; cyc(); inj_en = 0;
    err_clr = 1; cyc(); err_clr = 0;
    chk("clr_prio_err", err_count, 2'd0);
    chk("clr_prio_corr", correctable_error, 1'b1);

    // async reset mid-stream
    in_valid = 1; in_data = 32'hAAAA0001; cyc(); in_valid = 0;
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data_1, 32'h0);
    chk("arst_ready", in_ready, 1'b0);
    chk("arst_err", err_count, 2'd0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("arst_rel_ready", in_ready, 1'b1);
    chk("arst_rel_valid", out_valid, 1'b0);
    out_ready = 1;
    in_valid = 1; in_data = 32'hCAFEBABE; cyc(); in_valid = 0;
    cyc(); cyc();
    chk("final_empty", out_valid, 1'b0);
    chk("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
